// File: rtl/pipelined_cla_adder.sv
// Pipelined block carry-lookahead adder/subtractor with valid/ready handshake.
// Each pipeline stage adds one WIDTH/STAGES segment; carries and pending operands ride along.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLOCK;

  if ((STAGES < 1) || ((WIDTH % STAGES) != 0) || (((WIDTH / STAGES) % BLOCK) != 0)) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must split into STAGES segments of whole BLOCK groups");
  end

  // One segment: BLOCK-bit groups with lookahead G/P, group carries rippled between groups.
  function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           cin);
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG-1:0] sum;
    logic           c_grp;
    logic           c_bit;
    logic           grp_g;
    logic           grp_p;
    g     = a & b;
    p     = a ^ b;
    sum   = '0;
    c_grp = cin;
    for (int k = 0; k < NGRP; k++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      c_bit = c_grp;
      for (int i = 0; i < BLOCK; i++) begin
        grp_g              = g[k*BLOCK+i] | (p[k*BLOCK+i] & grp_g);
        grp_p              = grp_p & p[k*BLOCK+i];
        sum[k*BLOCK+i]     = p[k*BLOCK+i] ^ c_bit;
        c_bit              = g[k*BLOCK+i] | (p[k*BLOCK+i] & c_bit);
      end
      c_grp = grp_g | (grp_p & c_grp);
    end
    return {c_grp, sum};
  endfunction

  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic [STAGES-1:0]            vld_q, vld_d;
  logic [STAGES-1:0]            cy_q, cy_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic                         ovf_q, ovf_d;
  logic                         stall_s;

  // Next-state for every stage; a global stall freezes the whole pipe, bubbles included.
  always_comb begin
    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic [SEG:0]     seg;
    int               prev;
    v_in    = 1'b0;
    c_in    = 1'b0;
    a_in    = '0;
    b_in    = '0;
    sum_in  = '0;
    seg     = '0;
    prev    = 0;
    stall_s = vld_q[STAGES-1] & ~i_ready;
    vld_d   = vld_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    for (int s = 0; s < STAGES; s++) begin
      prev = (s > 0) ? (s - 1) : 0;
      if (s == 0) begin
        v_in   = i_valid;
        a_in   = i_add1;
        b_in   = i_add2 ^ {WIDTH{i_sub}};
        c_in   = i_carry ^ i_sub;
        sum_in = '0;
      end else begin
        v_in   = vld_q[prev];
        a_in   = a_q[prev];
        b_in   = b_q[prev];
        c_in   = cy_q[prev];
        sum_in = sum_q[prev];
      end
      seg                   = cla_seg(a_in[s*SEG +: SEG], b_in[s*SEG +: SEG], c_in);
      sum_in[s*SEG +: SEG]  = seg[SEG-1:0];
      if (stall_s) begin
        vld_d[s] = vld_q[s];
      end else begin
        vld_d[s] = v_in;
        if (v_in) begin
          a_d[s]   = a_in;
          b_d[s]   = b_in;
          sum_d[s] = sum_in;
          cy_d[s]  = seg[SEG];
          ovf_d    = (s == STAGES - 1) ? ovf_of(a_in[WIDTH-1], b_in[WIDTH-1], sum_in[WIDTH-1]) : ovf_d;
        end else begin
          a_d[s]   = a_q[s];
          b_d[s]   = b_q[s];
          sum_d[s] = sum_q[s];
          cy_d[s]  = cy_q[s];
        end
      end
    end
  end

  // Pipeline registers; reset drops every in-flight transaction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_ready    = ~stall_s;
  assign o_valid    = vld_q[STAGES-1];
  assign o_result   = {cy_q[STAGES-1], sum_q[STAGES-1]};
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench: directed 8-bit/2-stage checks, then random 64-bit/4-stage traffic.
module tb_pipelined_cla_adder;

  logic        clk;
  logic        rst_n;

  logic        v8, r8, c8, s8, ordy8, ovld8, ovf8;
  logic [7:0]  a8, b8;
  logic [8:0]  res8;

  logic        v64, r64, c64, s64, ordy64, ovld64, ovf64;
  logic [63:0] a64, b64;
  logic [64:0] res64;

  logic [9:0]  q8[$];
  logic [65:0] q64[$];

  int n_checks = 0;
  int n_errors = 0;

  pipelined_cla_adder #(.WIDTH(8), .BLOCK(4), .STAGES(2)) u_d8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(ordy8),
    .i_add1(a8), .i_add2(b8), .i_carry(c8), .i_sub(s8),
    .o_valid(ovld8), .i_ready(r8), .o_result(res8), .o_overflow(ovf8)
  );

  pipelined_cla_adder #(.WIDTH(64), .BLOCK(4), .STAGES(4)) u_d64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v64), .o_ready(ordy64),
    .i_add1(a64), .i_add2(b64), .i_carry(c64), .i_sub(s64),
    .o_valid(ovld64), .i_ready(r64), .o_result(res64), .o_overflow(ovf64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] model64(input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic s);
    logic [63:0] bp;
    logic [64:0] sum;
    logic        ov;
    bp  = b ^ {64{s}};
    sum = {1'b0, a} + {1'b0, bp} + {64'd0, c ^ s};
    ov  = (a[63] == bp[63]) && (sum[63] != a[63]);
    return {ov, sum};
  endfunction

  // One cycle on the 8-bit DUT: drive, sample, pop/compare output, push accepted input.
  task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic s, input logic r, input logic [9:0] exp_in,
                       output logic rdy, output logic vld, output logic [8:0] res);
    logic [9:0] e;
    @(negedge clk);
    v8 = v; a8 = a; b8 = b; c8 = c; s8 = s; r8 = r;
    #1;
    rdy = ordy8; vld = ovld8; res = res8;
    if (ovld8 && r8) begin
      n_checks++;
      assert (q8.size() > 0) else begin
        n_errors++;
        $error("FAIL d8_spurious: observed output %h expected none", {ovf8, res8});
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("d8_result", {56'd0, ovf8, res8}, {56'd0, e});
      end
    end
    if (v && ordy8) q8.push_back(exp_in);
  endtask

  task automatic step64(input logic v, input logic r, output logic accepted);
    logic [65:0] e;
    @(negedge clk);
    v64 = v; r64 = r;
    a64 = {$urandom(), $urandom()};
    b64 = {$urandom(), $urandom()};
    c64 = 1'($urandom_range(0, 1));
    s64 = 1'($urandom_range(0, 1));
    #1;
    accepted = v && ordy64;
    if (ovld64 && r64) begin
      n_checks++;
      assert (q64.size() > 0) else begin
        n_errors++;
        $error("FAIL d64_spurious: observed output %h expected none", {ovf64, res64});
      end
      if (q64.size() > 0) begin
        e = q64.pop_front();
        chk("d64_result", {ovf64, res64}, e);
      end
    end
    if (accepted) q64.push_back(model64(a64, b64, c64, s64));
  endtask

  initial begin
    logic       rdy, vld, acc;
    logic [8:0] res;
    int         n_sent;
    int         cyc;

    rst_n = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; s8 = 1'b0; r8 = 1'b1;
    v64 = 1'b0; a64 = 64'd0; b64 = 64'd0; c64 = 1'b0; s64 = 1'b0; r64 = 1'b1;
    #12;
    chk("rst_valid", {65'd0, ovld8}, 66'd0);
    chk("rst_result", {57'd0, res8}, 66'd0);
    chk("rst_ovf", {65'd0, ovf8}, 66'd0);
    chk("rst_ready", {65'd0, ordy8}, 66'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry-out with latency check
    step8(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 10'h100, rdy, vld, res);
    chk("t1_ready", {65'd0, rdy}, 66'd1);
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, rdy, vld, res);
    chk("t1_lat_early", {65'd0, vld}, 66'd0);
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, rdy, vld, res);
    chk("t1_lat_valid", {65'd0, vld}, 66'd1);

    // Overflow and subtract, back to back
    step8(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, {1'b1, 9'h080}, rdy, vld, res);
    step8(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, {1'b1, 9'h100}, rdy, vld, res);
    step8(1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1, {1'b0, 9'h0FE}, rdy, vld, res);
    step8(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b1, {1'b1, 9'h17F}, rdy, vld, res);
    step8(1'b1, 8'h10, 8'h01, 1'b1, 1'b1, 1'b1, {1'b0, 9'h10E}, rdy, vld, res);
    for (int i = 0; i < 10 && q8.size() != 0; i++)
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, rdy, vld, res);
    chk("t23_drain", 66'(q8.size()), 66'd0);

    // Backpressure: three stalled cycles holding the first result
    step8(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 10'h002, rdy, vld, res);
    step8(1'b1, 8'h02, 8'h02, 1'b0, 1'b0, 1'b1, 10'h004, rdy, vld, res);
    for (int i = 0; i < 3; i++) begin
      step8(1'b1, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 10'h006, rdy, vld, res);
      chk("t4_stall_ready", {65'd0, rdy}, 66'd0);
      chk("t4_stall_valid", {65'd0, vld}, 66'd1);
      chk("t4_stall_hold", {57'd0, res}, 66'h002);
    end
    step8(1'b1, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1, 10'h006, rdy, vld, res);
    chk("t4_resume_ready", {65'd0, rdy}, 66'd1);
    step8(1'b1, 8'h04, 8'h04, 1'b0, 1'b0, 1'b1, 10'h008, rdy, vld, res);
    for (int i = 0; i < 10 && q8.size() != 0; i++)
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, rdy, vld, res);
    chk("t4_drain", 66'(q8.size()), 66'd0);

    // Reset with two transactions in flight
    step8(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 10'h003, rdy, vld, res);
    step8(1'b1, 8'h03, 8'h03, 1'b0, 1'b0, 1'b1, 10'h006, rdy, vld, res);
    @(negedge clk);
    v8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {65'd0, ovld8}, 66'd0);
    chk("t5_rst_result", {57'd0, res8}, 66'd0);
    chk("t5_rst_ready", {65'd0, ordy8}, 66'd1);
    #1 rst_n = 1'b1;
    q8.delete();
    for (int i = 0; i < 3; i++) begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, rdy, vld, res);
      chk("t5_quiet", {65'd0, vld}, 66'd0);
    end
    step8(1'b1, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1, 10'h007, rdy, vld, res);
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, rdy, vld, res);
    chk("t5_new_early", {65'd0, vld}, 66'd0);
    step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h000, rdy, vld, res);
    chk("t5_new_valid", {65'd0, vld}, 66'd1);

    // Random 64-bit traffic with random valid/ready
    n_sent = 0;
    cyc = 0;
    while (n_sent < 10000 && cyc < 60000) begin
      step64($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
      if (acc) n_sent++;
      cyc++;
    end
    chk("t6_sent", 66'(n_sent), 66'd10000);
    for (int i = 0; i < 50 && q64.size() != 0; i++)
      step64(1'b0, 1'b1, acc);
    chk("t6_drain", 66'(q64.size()), 66'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
